// File: rtl/ln_unit.sv
// ============================================================================
//  Module      : ln_unit
//  Description : Iterative natural logarithm. Unsigned Q16.16 in, signed
//                Q8.8 ln(x) out. Leading-one normalisation, FRAC_ITER
//                squaring steps for the log2 fraction, then a ln2 scale.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ln_unit #(
  parameter int          FRAC_ITER = 12,
  parameter logic [15:0] LN2_Q16   = 16'hB172
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] number,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        zero_err
);

  // {int, frac} width, and the product width after the ln2 multiply
  localparam int L_W   = 6 + FRAC_ITER;
  localparam int P_W   = L_W + 17;
  localparam int CNT_W = $clog2(FRAC_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_ITER - 1);
  // Half of one Q8.8 LSB expressed in product units, for round half up
  localparam logic signed [P_W-1:0] RND_HALF = P_W'(1) << (FRAC_ITER + 7);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NORM  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [31:0]          num_q, num_d;
  logic [31:0]          m_q, m_d;
  logic signed [5:0]    int_q, int_d;
  logic [FRAC_ITER-1:0] frac_q, frac_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          result_q, result_d;
  logic                 zero_err_q, zero_err_d;

  logic [4:0]           msb_pos;
  logic [63:0]          sq;
  logic signed [L_W-1:0] l_val;
  logic signed [P_W-1:0] p_val;
  logic signed [P_W-1:0] p_rnd;

  // Position of the most significant set bit of the latched operand
  always_comb begin
    msb_pos = '0;
    for (int i = 0; i < 32; i++) begin
      if (num_q[i]) msb_pos = 5'(i);
    end
  end

  // Q1.31 mantissa squared gives Q2.62; ln2 scaling of the log2 value
  assign sq    = 64'(m_q) * 64'(m_q);
  assign l_val = {int_q, frac_q};
  assign p_val = $signed(l_val) * $signed({1'b0, LN2_Q16});
  assign p_rnd = p_val + RND_HALF;

  // State register; async reset aborts any computation in flight
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = (number == 32'd0) ? S_DONE : S_NORM;
      S_NORM:  state_d = S_ITER;
      S_ITER:  if (cnt_q == CNT_LAST) state_d = S_SCALE;
      S_SCALE: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next values for each phase of the computation
  always_comb begin
    num_d      = num_q;
    m_d        = m_q;
    int_d      = int_q;
    frac_d     = frac_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_err_d = zero_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          num_d = number;
          if (number == 32'd0) begin
            result_d   = 16'h8000;
            zero_err_d = 1'b1;
          end
        end
      end
      S_NORM: begin
        m_d    = num_q << (5'd31 - msb_pos);
        int_d  = $signed({1'b0, msb_pos}) - 6'sd16;
        frac_d = '0;
        cnt_d  = '0;
      end
      S_ITER: begin
        // A square >= 2 yields a 1 fraction bit and is renormalised by 2
        frac_d = {frac_q[FRAC_ITER-2:0], sq[63]};
        m_d    = sq[63] ? 32'(sq >> 32) : 32'(sq >> 31);
        cnt_d  = cnt_q + 1'b1;
      end
      S_SCALE: begin
        result_d   = 16'(p_rnd >>> (FRAC_ITER + 8));
        zero_err_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      num_q      <= '0;
      m_q        <= '0;
      int_q      <= '0;
      frac_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_err_q <= 1'b0;
    end else begin
      num_q      <= num_d;
      m_q        <= m_d;
      int_q      <= int_d;
      frac_q     <= frac_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      zero_err_q <= zero_err_d;
    end
  end

  assign result   = result_q;
  assign zero_err = zero_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ln_unit.sv
// ============================================================================
//  Module      : tb_ln_unit
//  Description : Self-checking bench for ln_unit against an ideal ln() model
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ln_unit;

  logic        clk = 1'b0;
  logic        _reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] number;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ln_unit dut (
    .clk       (clk),
    ._reset    (_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .number    (number),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_err  (zero_err)
  );

  // Ideal model: round(ln(x / 2^16) * 256)
  function automatic int ideal_ln(input logic [31:0] x);
    real r;
    r = $ln(real'(x) / 65536.0) * 256.0;
    return int'($floor(r + 0.5));
  endfunction

  // One full transaction; lat counts edges from the accepting edge (=1)
  task automatic transact(input logic [31:0] x, output logic [15:0] res,
                          output logic ze, output int lat);
    @(negedge clk);
    number   = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    number   = $urandom;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout x=%h: out_valid=%b after %0d clocks, required 1", x, out_valid, lat);
    end
    res = result;
    ze  = zero_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || zero_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h zero_err=%b, required 1 0 0000 0",
               in_ready, out_valid, result, zero_err);
    end
  endtask

  task automatic test_reset_mid_iter();
    logic [15:0] res;
    logic        ze;
    int          lat;
    bit          stale;
    transact(32'h0002_0000, res, ze, lat);
    @(negedge clk);
    number   = 32'h0001_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    _reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000 || zero_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_iter_reset: out_valid=%b in_ready=%b result=%h zero_err=%b, required 0 1 0000 0",
               out_valid, in_ready, result, zero_err);
    end
    #2;
    _reset = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    vectors++;
    if (stale) begin
      miscompares++;
      $display("FAIL stale_after_reset: out_valid rose after abort, required 0");
    end
  endtask

  task automatic test_known();
    logic [31:0] xs  [6] = '{32'h0001_0000, 32'h0002_0000, 32'h0002_B7E1,
                             32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    int          exr [6] = '{0, 177, 256, -2839, 2839, -32768};
    int          tol [6] = '{0, 0, 1, 0, 1, 0};
    logic        exz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          exl [6] = '{15, 15, 15, 15, 15, 1};
    logic [15:0] res;
    logic        ze;
    int          lat;
    int          diff;
    for (int k = 0; k < 6; k++) begin
      transact(xs[k], res, ze, lat);
      diff = $signed(res);
      diff = diff - exr[k];
      vectors++;
      if (diff > tol[k] || diff < -tol[k]) begin
        miscompares++;
        $display("FAIL known_result x=%h: got %h, required %h +/-%0d", xs[k], res, 16'(exr[k]), tol[k]);
      end
      vectors++;
      if (ze !== exz[k]) begin
        miscompares++;
        $display("FAIL known_zero_err x=%h: got %b, required %b", xs[k], ze, exz[k]);
      end
      vectors++;
      if (lat != exl[k]) begin
        miscompares++;
        $display("FAIL known_latency x=%h: got %0d, required %0d", xs[k], lat, exl[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          expv;
    int          wait_n;
    logic [15:0] res;
    logic        ze;
    int          lat;
    int          diff;
    expv = ideal_ln(32'h0004_0000);
    @(negedge clk);
    number   = 32'h0004_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_n = 0;
    while (out_valid !== 1'b1 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      number   = $urandom;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'(expv)) begin
        miscompares++;
        $display("FAIL hold_done cycle %0d: out_valid=%b in_ready=%b result=%h, required 1 0 %h",
                 i, out_valid, in_ready, result, 16'(expv));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'(expv)) begin
      miscompares++;
      $display("FAIL after_handshake: out_valid=%b in_ready=%b result=%h, required 0 1 %h",
               out_valid, in_ready, result, 16'(expv));
    end
    transact(32'h0000_8000, res, ze, lat);
    diff = $signed(res);
    diff = diff - ideal_ln(32'h0000_8000);
    vectors++;
    if (diff > 1 || diff < -1 || lat != 15) begin
      miscompares++;
      $display("FAIL next_word: result=%h latency=%0d, required %h +/-1 latency 15",
               res, lat, 16'(ideal_ln(32'h0000_8000)));
    end
  endtask

  task automatic test_random_raw();
    logic [31:0] x;
    logic [15:0] res;
    logic        ze;
    int          lat;
    int          diff;
    for (int k = 0; k < 24; k++) begin
      x = $urandom >> $urandom_range(0, 31);
      if (x == 32'd0) x = 32'd1;
      transact(x, res, ze, lat);
      diff = $signed(res);
      diff = diff - ideal_ln(x);
      vectors++;
      if (diff > 1 || diff < -1 || ze !== 1'b0) begin
        miscompares++;
        $display("FAIL random_raw x=%h: result=%h zero_err=%b, required %h +/-1 zero_err 0",
                 x, res, ze, 16'(ideal_ln(x)));
      end
    end
  endtask

  // Exponent-style round trip: Q8.8 y -> Q16.16 exp(y) -> ln -> y
  task automatic test_exp_roundtrip();
    int          y;
    real         xr;
    logic [31:0] x;
    logic [15:0] res;
    logic        ze;
    int          lat;
    int          diff;
    for (int k = 0; k < 16; k++) begin
      y  = int'($urandom_range(0, 4039)) - 1200;
      xr = $exp(real'(y) / 256.0) * 65536.0;
      if (xr > 4294967295.0) xr = 4294967295.0;
      x = 32'(longint'($floor(xr + 0.5)));
      if (x == 32'd0) x = 32'd1;
      transact(x, res, ze, lat);
      diff = $signed(res);
      diff = diff - y;
      vectors++;
      if (diff > 2 || diff < -2) begin
        miscompares++;
        $display("FAIL exp_roundtrip y=%0d x=%h: result=%h, required %h +/-2", y, x, res, 16'(y));
      end
    end
  endtask

  initial begin
    _reset    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    number    = 32'd0;
    #12;
    test_reset();
    _reset = 1'b1;
    test_known();
    test_reset_mid_iter();
    test_backpressure();
    test_random_raw();
    test_exp_roundtrip();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
